aes_spi_host: RTL and testbench
===============================

# aes_spi_host

Host-side serial link controller for the AES core's SPI-style port. It serialises a 128-bit plaintext and a 128/192/256-bit key onto the link, waits a fixed processing interval, then frames a second transfer and deserialises the 128-bit processed block returned by the device. It sits between the system-side register interface and the AES device's serial pins: `sdo` drives the device's serial data input and `sdi` receives its serial data output.

## Interface
Parameters:
- `WAIT_CYCLES`, default 16: clocks `cs` is held low between the load transfer and the readback transfer. Legal range is 2 or more.
- `GAP_CYCLES`, default 2: minimum clocks `cs` stays low after any transfer before `done` or the next phase. Legal range is 1 or more.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: single clock. It also serves as the serial bit clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a full operation. Sampled only in IDLE.
- `key_len` in 2: key size. 0 = 128 bits, 1 = 192, 2 = 256, 3 = 256.
- `message` in 128: plaintext, captured when `start` is accepted.
- `key` in 256: key, captured when `start` is accepted. Only `key[keybits-1:0]` is sent.
- `sdi` in 1: serial data from the device.
- `cs` out 1: frame enable, active-high.
- `sdo` out 1: serial data to the device.
- `result` out 128: processed block. It is held until the next accepted `start`.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when `result` is valid.

## Operation
- Reset values: `cs`=0, `sdo`=0, `result`=0, `busy`=0, `done`=0, state IDLE, bit counter 0, captured registers 0.
- States:
  - IDLE: on `start`=1, capture `message`, `key` and `key_len`. Set `busy`=1 and go to LOAD. `start` is ignored in every other state.
  - LOAD: `cs`=1 for exactly N = 128 + keybits clocks (256, 320 or 384). In load-cycle k (k = 0..N-1), `sdo` = `message[k]` for k < 128, and `key[k-128]` otherwise. Bits go out LSB-first: message first, then key. After cycle N-1, go to GAP1.
  - GAP1: `cs`=0 and `sdo`=0 for `WAIT_CYCLES` clocks. This low interval is what switches the device to output mode. Then go to READ.
  - READ: `cs`=1 for exactly 128 clocks. The value of `sdi` sampled at the end of read-cycle k is written into `result[k]`, LSB-first. `sdo` is held at 0. After cycle 127, go to GAP2.
  - GAP2: `cs`=0 for `GAP_CYCLES` clocks. On the last of these clocks, pulse `done`=1. On the following clock, drop `busy` and return to IDLE.
- The bit counter is 9 bits wide. It is cleared on every state entry. Terminal-count comparison uses N as computed from the captured `key_len`.
- `result` bits are updated in place during READ. A consumer may only trust `result` on `done` and afterwards.
- `rst` asserted in any state, including mid-LOAD or mid-READ, forces the reset values on the next edge. `cs` falls immediately, which aborts the device frame. No `done` is issued.
- If `start` and `rst` are asserted together, `rst` wins.
- Changing `message`, `key` or `key_len` after capture has no effect on the operation in progress.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Load-cycle 0 is the first clock with `cs`=1. `sdo` carries `message[0]` during that same clock, so `cs` and `sdo` rise on the same edge.
- The device samples `sdo` on the rising edge that ends each cs-high cycle. It drives `sdi` from its falling edge, so `sdi` is stable at the host's rising-edge sample.
- Latency from the accepting `start` edge to `done`, in clocks: 1 + N + `WAIT_CYCLES` + 128 + `GAP_CYCLES`. For `key_len`=0 with default parameters this is 1 + 256 + 16 + 128 + 2 = 403.
- The earliest next accepted `start` is the clock after `busy` falls.

## Test plan
- Reset, then `key_len`=0, `message`=128'h00112233445566778899aabbccddeeff, `key`=128'h000102030405060708090a0b0c0d0e0f, device model returning 128'h69c4e0d86a7b0430d8cdb78070b4c55a. Required: `cs` high for 256 clocks, low for 16, high for 128; serial stream equals message then key, LSB-first; `result` equals the returned block; `done` at clock 403.
- `key_len`=1 and `key_len`=2 (and 3). Required: load window of 320 and 384 clocks respectively (384 for 3); bits 320..383 appear only when 256-bit.
- `start` pulsed repeatedly during LOAD and READ. Required: no restart; exactly one `done`; captured inputs unchanged.
- `rst` asserted at load-cycle 200, then again at read-cycle 64. Required: `cs`=0, `result`=0, `busy`=0 on the next edge; no `done`; a following clean operation completes correctly.
- `start` and `rst` asserted in the same cycle. Required: stays in IDLE, `busy`=0.
- `WAIT_CYCLES`=2, `GAP_CYCLES`=1 with back-to-back `start` on the clock after `busy` falls. Required: two correct `done` pulses; minimum `cs`-low widths respected.

Source files
------------

// File: rtl/aes_spi_host_if.sv
// aes_spi_host_if
// Bundles the request/response side and the serial pins of aes_spi_host.
//   start    : one-cycle request, sampled by the host only while idle
//   key_len  : 0 = 128-bit key, 1 = 192, 2/3 = 256
//   message  : 128-bit plaintext, captured with start
//   key      : 256-bit key field, captured with start (low keybits used)
//   result   : 128-bit block read back from the device
//   busy     : high from the accepted start until done
//   done     : one-cycle pulse, result valid from here on
//   cs, sdo  : frame enable and serial data towards the device
//   sdi      : serial data from the device
// Modports: slave = the host controller, master = requester / device side.
interface aes_spi_host_if;
  logic         start;
  logic [1:0]   key_len;
  logic [127:0] message;
  logic [255:0] key;
  logic         sdi;
  logic         cs;
  logic         sdo;
  logic [127:0] result;
  logic         busy;
  logic         done;

  modport slave (
    input  start, key_len, message, key, sdi,
    output cs, sdo, result, busy, done
  );

  modport master (
    output start, key_len, message, key, sdi,
    input  cs, sdo, result, busy, done
  );
endinterface

// File: rtl/aes_spi_host.sv
// aes_spi_host
// Host-side serial link controller for the AES core's SPI-style port.
// One operation: shift out message then key LSB-first in a single cs frame,
// hold cs low for WAIT_CYCLES, shift in a 128-bit block in a second frame,
// hold cs low for GAP_CYCLES and pulse done on the last of those clocks.
// Ports:
//   clk : single clock, also the serial bit clock
//   rst : synchronous, active-high reset
//   bus : aes_spi_host_if.slave (start/key_len/message/key/sdi in,
//         cs/sdo/result/busy/done out, all outputs registered)
module aes_spi_host #(
  parameter int WAIT_CYCLES = 16,
  parameter int GAP_CYCLES  = 2
) (
  input logic           clk,
  input logic           rst,
  aes_spi_host_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP1,
    S_READ,
    S_GAP2
  } state_e;

  localparam logic [8:0] WAIT_LAST = 9'(WAIT_CYCLES - 1);
  localparam logic [8:0] GAP_LAST  = 9'(GAP_CYCLES - 1);
  localparam logic [8:0] READ_LAST = 9'd127;

  state_e       state_q;
  logic [8:0]   cnt_q;
  logic [1:0]   key_len_q;
  logic [127:0] message_q;
  logic [255:0] key_q;
  logic         cs_q;
  logic         sdo_q;
  logic         busy_q;
  logic         done_q;
  logic [127:0] result_q;

  logic [8:0]   load_len_d;
  logic [383:0] load_vec_d;

  // Load frame length N = 128 + keybits, from the captured key size.
  always_comb begin
    unique case (key_len_q)
      2'd0:    load_len_d = 9'd256;
      2'd1:    load_len_d = 9'd320;
      default: load_len_d = 9'd384;
    endcase
  end

  // Serial order is message[0..127] then key[0..]; bits past N are never sent.
  assign load_vec_d = {key_q, message_q};

  // In every state the counter indexes the value the outputs take on the
  // *next* clock, so cs/sdo stay purely registered. LOAD therefore spends
  // one clock with cs still low before load-cycle 0.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: captured operands are cleared too, so an aborted operation
      // leaves no stale key material behind.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_len_q <= '0;
      message_q <= '0;
      key_q     <= '0;
      cs_q      <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            message_q <= bus.message;
            key_q     <= bus.key;
            key_len_q <= bus.key_len;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (cnt_q == load_len_d) begin
            cs_q    <= 1'b0;
            sdo_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_GAP1;
          end else begin
            cs_q  <= 1'b1;
            sdo_q <= load_vec_d[cnt_q];
            cnt_q <= cnt_q + 9'd1;
          end
        end

        // cs low for WAIT_CYCLES switches the device to output mode.
        S_GAP1: begin
          if (cnt_q == WAIT_LAST) begin
            cs_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_READ;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        // sdi is sampled at the edge that closes read-cycle cnt_q.
        S_READ: begin
          result_q[cnt_q[6:0]] <= bus.sdi;
          if (cnt_q == READ_LAST) begin
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            // With a one-clock gap the first gap clock is also the last.
            done_q  <= (GAP_LAST == 9'd0);
            state_q <= S_GAP2;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end

        S_GAP2: begin
          if (cnt_q == GAP_LAST) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            done_q <= (cnt_q + 9'd1 == GAP_LAST);
            cnt_q  <= cnt_q + 9'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cs     = cs_q;
  assign bus.sdo    = sdo_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_aes_spi_host.sv
// tb_aes_spi_host
// Two hosts: unit 0 with default timing (16/2) and unit 1 with the shortest
// legal timing (2/1). Stimulus pushes one expected transaction per accepted
// start; a negedge process acts as the AES device (captures the load frame,
// returns the chosen block on sdi) and pops/compares on every done.
module tb_aes_spi_host;
  localparam int W0 = 16;
  localparam int G0 = 2;
  localparam int W1 = 2;
  localparam int G1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_spi_host_if if0 ();
  aes_spi_host_if if1 ();

  aes_spi_host #(.WAIT_CYCLES(W0), .GAP_CYCLES(G0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  aes_spi_host #(.WAIT_CYCLES(W1), .GAP_CYCLES(G1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    int           unit;
    logic [1:0]   kl;
    logic [127:0] msg;
    logic [255:0] key;
    logic [127:0] resp;
    int           accept;
    int           nbits;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-unit device-model state.
  bit           in_frame   [2];
  int           phase      [2];
  int           fcnt       [2];
  int           low_run    [2];
  logic [383:0] bits       [2];
  bit           rd_sdo_bad [2];
  bit           gap_sdo_bad[2];
  bit           after_done [2];

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int key_bits(input logic [1:0] kl);
    case (kl)
      2'd0:    return 128;
      2'd1:    return 192;
      default: return 256;
    endcase
  endfunction

  function automatic int wait_of(input int u);
    return (u == 0) ? W0 : W1;
  endfunction

  function automatic int gap_of(input int u);
    return (u == 0) ? G0 : G1;
  endfunction

  // Expected serial stream: message, then only the low keybits of the key.
  function automatic logic [383:0] load_stream(input logic [1:0] kl, input logic [127:0] msg,
                                               input logic [255:0] key);
    logic [255:0] mask;
    mask = {256{1'b1}} >> (256 - key_bits(kl));
    return {key & mask, msg};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 0) ? if0.busy : if1.busy;
  endfunction

  task automatic drive_req(input int u, input logic st, input logic [1:0] kl,
                           input logic [127:0] msg, input logic [255:0] key);
    if (u == 0) begin
      if0.start = st; if0.key_len = kl; if0.message = msg; if0.key = key;
    end else begin
      if1.start = st; if1.key_len = kl; if1.message = msg; if1.key = key;
    end
  endtask

  // Called just after a rising edge while the unit is idle; start is
  // accepted on the next edge, then the request lines are scrambled.
  task automatic run_op(input int u, input logic [1:0] kl, input logic [127:0] msg,
                        input logic [255:0] key, input logic [127:0] resp);
    exp_t e;
    e.unit   = u;
    e.kl     = kl;
    e.msg    = msg;
    e.key    = key;
    e.resp   = resp;
    e.nbits  = 128 + key_bits(kl);
    e.lat    = 1 + e.nbits + wait_of(u) + 128 + gap_of(u);
    e.accept = cyc + 1;
    exp_q.push_back(e);
    drive_req(u, 1'b1, kl, msg, key);
    @(posedge clk); #1;
    drive_req(u, 1'b0, 2'($urandom), rand128(), rand256());
  endtask

  // Returns just after the edge on which busy falls.
  task automatic wait_idle(input int u);
    for (int i = 0; i < 3000 && busy_of(u); i++) begin
      @(posedge clk); #1;
    end
    check("idle_timeout", 384'(busy_of(u)), 384'(0));
  endtask

  task automatic dev_step(input int u, input logic cs, input logic sdo, input logic busy,
                          input logic done, input logic [127:0] result, output logic sdi_o);
    logic have;
    exp_t e;
    sdi_o = 1'($urandom);
    have  = (exp_q.size() > 0) && (exp_q[0].unit == u);
    if (have) e = exp_q[0];

    if (after_done[u]) begin
      after_done[u] = 1'b0;
      check("busy_drop", 384'(busy), 384'(0));
      check("done_width", 384'(done), 384'(0));
    end

    if (!busy) begin
      in_frame[u] = 1'b0;
      phase[u]    = 0;
    end

    if (cs) begin
      if (!in_frame[u]) begin
        in_frame[u]   = 1'b1;
        fcnt[u]       = 0;
        bits[u]       = '0;
        rd_sdo_bad[u] = 1'b0;
        check("frame_owner", 384'(have && phase[u] < 2), 384'(1));
        if (phase[u] == 0) begin
          check("load_start", 384'(cyc - e.accept), 384'(1));
          check("min_cs_low", 384'(low_run[u] >= gap_of(u)), 384'(1));
        end else begin
          check("gap1_len", 384'(low_run[u]), 384'(wait_of(u)));
          check("gap1_sdo", 384'(gap_sdo_bad[u]), 384'(0));
        end
        low_run[u] = 0;
      end
      if (phase[u] == 0) begin
        if (fcnt[u] < 384) bits[u][fcnt[u]] = sdo;
      end else begin
        rd_sdo_bad[u] = rd_sdo_bad[u] | sdo;
        if (have && fcnt[u] < 128) sdi_o = e.resp[fcnt[u]];
      end
      fcnt[u]++;
    end else begin
      low_run[u]++;
      if (in_frame[u]) begin
        in_frame[u] = 1'b0;
        if (phase[u] == 0) begin
          check("load_len", 384'(fcnt[u]), 384'(e.nbits));
          check("load_bits", bits[u], load_stream(e.kl, e.msg, e.key));
          phase[u]       = 1;
          gap_sdo_bad[u] = 1'b0;
        end else begin
          check("read_len", 384'(fcnt[u]), 384'(128));
          check("read_sdo", 384'(rd_sdo_bad[u]), 384'(0));
          phase[u] = 2;
        end
      end
      if (phase[u] == 1 && busy) gap_sdo_bad[u] = gap_sdo_bad[u] | sdo;
    end

    if (done) begin
      check("done_owner", 384'(have), 384'(1));
      if (have) begin
        exp_q.delete(0);
        check("result", 384'(result), 384'(e.resp));
        check("latency", 384'(cyc - e.accept + 1), 384'(e.lat));
        check("gap2_len", 384'(low_run[u]), 384'(gap_of(u)));
        check("done_phase", 384'(phase[u]), 384'(2));
        check("done_busy", 384'(busy), 384'(1));
        after_done[u] = 1'b1;
      end
    end
  endtask

  logic sdi0, sdi1;
  always @(negedge clk) begin
    dev_step(0, if0.cs, if0.sdo, if0.busy, if0.done, if0.result, sdi0);
    dev_step(1, if1.cs, if1.sdo, if1.busy, if1.done, if1.result, sdi1);
    if0.sdi = sdi0;
    if1.sdi = sdi1;
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cs"}, 384'(if0.cs), 384'(0));
    check({tag, "_result"}, 384'(if0.result), 384'(0));
    check({tag, "_busy"}, 384'(if0.busy), 384'(0));
    check({tag, "_done"}, 384'(if0.done), 384'(0));
  endtask

  initial begin
    logic [1:0]   kl;
    logic [127:0] resp;
    rst = 1'b1;
    drive_req(0, 1'b0, 2'd0, '0, '0);
    drive_req(1, 1'b0, 2'd0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    check("reset_sdo", 384'(if0.sdo), 384'(0));
    check("reset_u1_busy", 384'(if1.busy), 384'(0));
    check("reset_u1_cs", 384'(if1.cs), 384'(0));

    // Directed vector.
    @(posedge clk); #1;
    run_op(0, 2'd0, 128'h00112233445566778899aabbccddeeff,
           256'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_idle(0);

    // Remaining key sizes with random data.
    for (int k = 1; k < 4; k++) begin
      run_op(0, 2'(k), rand128(), rand256(), rand128());
      wait_idle(0);
    end

    // start (and request data) toggled throughout an operation.
    run_op(0, 2'($urandom), rand128(), rand256(), rand128());
    for (int i = 0; i < 3000 && if0.busy; i++) begin
      drive_req(0, 1'($urandom), 2'($urandom), rand128(), rand256());
      @(posedge clk); #1;
    end
    drive_req(0, 1'b0, 2'($urandom), rand128(), rand256());
    check("spam_idle_timeout", 384'(if0.busy), 384'(0));

    // Reset during load-cycle 200.
    kl = 2'($urandom);
    run_op(0, kl, rand128(), rand256(), rand128());
    repeat (201) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_load");
    #1 exp_q.delete();

    // Reset during read-cycle 64; response bit 0 set so result is nonzero.
    @(posedge clk); #1;
    kl   = 2'($urandom);
    resp = rand128() | 128'd1;
    run_op(0, kl, rand128(), rand256(), resp);
    repeat (1 + 128 + key_bits(kl) + W0 + 64) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_read");
    #1 exp_q.delete();

    // Clean operation after the aborts.
    @(posedge clk); #1;
    run_op(0, 2'($urandom), rand128(), rand256(), rand128());
    wait_idle(0);

    // start and rst together: reset wins.
    drive_req(0, 1'b1, 2'($urandom), rand128(), rand256());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(0, 1'b0, 2'($urandom), rand128(), rand256());
    @(negedge clk);
    check("start_rst_busy", 384'(if0.busy), 384'(0));
    check("start_rst_cs", 384'(if0.cs), 384'(0));
    repeat (4) @(negedge clk);
    check("start_rst_still_idle", 384'(if0.busy), 384'(0));

    // Short timing, back-to-back starts on the clock after busy falls.
    @(posedge clk); #1;
    run_op(1, 2'($urandom), rand128(), rand256(), rand128());
    wait_idle(1);
    run_op(1, 2'($urandom), rand128(), rand256(), rand128());
    wait_idle(1);

    // A few more random operations on the default-timed unit.
    for (int i = 0; i < 4; i++) begin
      run_op(0, 2'($urandom), rand128(), rand256(), rand128());
      wait_idle(0);
    end

    repeat (10) @(posedge clk);
    check("outstanding", 384'(exp_q.size()), 384'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
